// File: rtl/flash_sample_reader_if.sv
// flash_sample_reader_if: Avalon-MM read-only bus between the sample reader and the flash controller.
interface flash_sample_reader_if;
    logic        read;
    logic [22:0] address;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    modport master (output read, address, byteenable, input waitrequest, readdata, readdatavalid);
    modport slave (input read, address, byteenable, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: fetches one 32-bit flash word per address step and plays it out
// as two 16-bit samples, one per audio tick, tracking ticks that arrive with no sample ready.
module flash_sample_reader #(
    parameter int UNDERRUN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_tick,
    input  logic                    playpause,
    input  logic                    dir,
    input  logic [22:0]             addr,
    output logic                    addr_adv,
    flash_sample_reader_if.master   flash_mem,
    output logic [15:0]             audio_sample,
    output logic                    sample_valid,
    output logic [UNDERRUN_W-1:0]   underrun_cnt
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, SAMPLE_A, SAMPLE_B, ADVANCE} state_t;
    state_t                state_q, state_d;
    logic [22:0]           address_q, address_d;
    logic [31:0]           word_q, word_d;
    logic                  dir_q, dir_d;
    logic                  pending_q, pending_d;
    logic [15:0]           sample_q, sample_d;
    logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
    logic                  sampling, emit, capture, late_tick;
    always_comb begin
        sampling = state_q == SAMPLE_A || state_q == SAMPLE_B;
        emit = sampling && playpause && (sample_tick || pending_q);
        // data may already be valid in the same cycle the request is accepted
        capture = flash_mem.readdatavalid &&
                  (state_q == WAIT_DATA || (state_q == REQ && !flash_mem.waitrequest));
        late_tick = playpause && !sampling && sample_tick;
        state_d = state_q;
        address_d = address_q;
        case (state_q)
            IDLE: if (playpause) begin
                state_d = REQ;
                address_d = addr;
            end
            REQ: if (!flash_mem.waitrequest) state_d = capture ? SAMPLE_A : WAIT_DATA;
            WAIT_DATA: if (capture) state_d = SAMPLE_A;
            SAMPLE_A: if (emit) state_d = SAMPLE_B;
            SAMPLE_B: if (emit) state_d = ADVANCE;
            default: state_d = IDLE;
        endcase
        word_d = capture ? flash_mem.readdata : word_q;
        dir_d = capture ? dir : dir_q;
        // forward plays the low half first, reverse plays the high half first
        sample_d = emit ? (((state_q == SAMPLE_A) == dir_q) ? word_q[15:0] : word_q[31:16]) : sample_q;
        pending_d = late_tick || (playpause && !sampling && pending_q);
        underrun_d = (late_tick && pending_q && !(&underrun_q)) ? underrun_q + UNDERRUN_W'(1) : underrun_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            address_q <= '0;
            word_q <= '0;
            dir_q <= 1'b1;
            pending_q <= 1'b0;
            sample_q <= '0;
            underrun_q <= '0;
        end else begin
            state_q <= state_d;
            address_q <= address_d;
            word_q <= word_d;
            dir_q <= dir_d;
            pending_q <= pending_d;
            sample_q <= sample_d;
            underrun_q <= underrun_d;
        end
    end
    assign flash_mem.read = state_q == REQ;
    assign flash_mem.address = address_q;
    assign flash_mem.byteenable = 4'hF;
    assign addr_adv = state_q == ADVANCE;
    assign audio_sample = sample_d;
    assign sample_valid = emit;
    assign underrun_cnt = underrun_q;
endmodule

// File: tb/tb_flash_sample_reader.sv
// tb_flash_sample_reader: randomized flash slave and tick source against a queue-based
// playback model, plus directed scenarios with literal expectations.
module tb_flash_sample_reader;
    localparam int UW = 2;
    logic          clk = 1'b0, rst = 1'b1, sample_tick = 1'b0, playpause = 1'b0, dir = 1'b1;
    logic [22:0]   addr = '0;
    logic          addr_adv, sample_valid;
    logic [15:0]   audio_sample;
    logic [UW-1:0] underrun_cnt;
    int            checks = 0, failures = 0;

    flash_sample_reader_if flash ();

    flash_sample_reader #(.UNDERRUN_W(UW)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .playpause(playpause), .dir(dir),
        .addr(addr), .addr_adv(addr_adv), .flash_mem(flash), .audio_sample(audio_sample),
        .sample_valid(sample_valid), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // flash slave configuration and state
    int          ws_cfg = 0, lat_cfg = 1, ws_left = 0, lat_cnt = -1;
    bit          rand_mode = 0, fixed_en = 1, stray = 0;
    logic [31:0] fixed_data = '0;
    logic [22:0] pend_addr = '0;
    bit          s_adv, s_acc, s_rd, s_rst;
    logic [22:0] s_addr;

    function automatic logic [31:0] mem(input logic [22:0] a);
        return fixed_en ? fixed_data : {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    task automatic cyc(input bit tk);
        @(negedge clk);
        s_adv = addr_adv;
        s_acc = flash.read && !flash.waitrequest;
        s_addr = flash.address;
        s_rd = flash.read;
        s_rst = rst;
        @(posedge clk);
        #1;
        sample_tick = tk;
        flash.readdatavalid = 1'b0;
        if (s_rst) lat_cnt = -1;
        else begin
            if (s_adv) addr = dir ? addr + 23'd1 : addr - 23'd1;
            if (s_acc && lat_cfg > 0) begin
                lat_cnt = lat_cfg;
                pend_addr = s_addr;
            end
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    flash.readdatavalid = 1'b1;
                    flash.readdata = mem(pend_addr);
                    lat_cnt = -1;
                end
            end
        end
        if (flash.read && !s_rd) begin
            if (rand_mode) begin
                ws_cfg = $urandom_range(0, 3);
                lat_cfg = $urandom_range(0, 3);
            end
            ws_left = ws_cfg;
        end
        flash.waitrequest = flash.read && ws_left > 0;
        if (flash.waitrequest) ws_left--;
        else if (flash.read && lat_cfg == 0) begin
            flash.readdatavalid = 1'b1;
            flash.readdata = mem(flash.address);
        end
        if (stray && !flash.readdatavalid && lat_cnt < 0 && !flash.read) begin
            flash.readdatavalid = 1'b1;
            flash.readdata = 32'hDEAD_BEEF;
        end
        stray = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0);
        cyc(0);
        rst = 1'b0;
    endtask

    // playback model: buffered samples of the current word plus fetch progress flags
    logic [15:0] q[$];
    logic [15:0] m_held = '0, m_exp;
    logic [22:0] m_raddr = '0;
    int          m_unc = 0;
    bit          m_pend = 0, m_adv = 0, m_reading = 0, m_waiting = 0;
    bit          m_em, m_idle, m_acc, m_cap, prev_read = 0;
    logic [15:0] samp_log[$];
    logic [22:0] req_log[$];
    int          valid_cnt = 0, adv_cnt = 0, read_hi = 0;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_held = '0;
            m_unc = 0;
            m_pend = 0;
            m_adv = 0;
            m_reading = 0;
            m_waiting = 0;
        end
        m_em = q.size() > 0 && playpause && (sample_tick || m_pend);
        m_exp = m_em ? q[0] : m_held;
        check("sample_valid", 32'(sample_valid), 32'(m_em));
        check("audio_sample", 32'(audio_sample), 32'(m_exp));
        check("addr_adv", 32'(addr_adv), 32'(m_adv));
        check("read", 32'(flash.read), 32'(m_reading));
        check("underrun_cnt", 32'(underrun_cnt), 32'(m_unc));
        check("byteenable", 32'(flash.byteenable), 32'hF);
        if (m_reading) check("address", 32'(flash.address), 32'(m_raddr));
        if (sample_valid) begin
            valid_cnt++;
            samp_log.push_back(audio_sample);
        end
        if (addr_adv) adv_cnt++;
        if (flash.read) read_hi++;
        if (flash.read && !prev_read) req_log.push_back(flash.address);
        prev_read = flash.read;
        if (!rst) begin
            m_idle = q.size() == 0 && !m_adv && !m_reading && !m_waiting;
            m_acc = m_reading && !flash.waitrequest;
            m_cap = (m_acc || m_waiting) && flash.readdatavalid;
            if (!playpause || q.size() > 0) m_pend = 0;
            else if (sample_tick) begin
                if (m_pend && m_unc < (1 << UW) - 1) m_unc++;
                m_pend = 1;
            end
            m_adv = 0;
            if (m_em) begin
                m_held = q.pop_front();
                if (q.size() == 0) m_adv = 1;
            end
            if (m_idle && playpause) begin
                m_reading = 1;
                m_raddr = addr;
            end else if (m_acc) m_reading = 0;
            if (m_acc && !flash.readdatavalid) m_waiting = 1;
            if (m_cap) begin
                m_waiting = 0;
                q.push_back(dir ? flash.readdata[15:0] : flash.readdata[31:16]);
                q.push_back(dir ? flash.readdata[31:16] : flash.readdata[15:0]);
            end
        end
    end

    int sb, vb, ab, rb, hb;
    initial begin
        flash.waitrequest = 1'b0;
        flash.readdatavalid = 1'b0;
        flash.readdata = '0;
        cyc(0);
        cyc(0);
        check("rst_audio_sample", 32'(audio_sample), 32'h0);
        check("rst_sample_valid", 32'(sample_valid), 32'h0);
        check("rst_addr_adv", 32'(addr_adv), 32'h0);
        check("rst_read", 32'(flash.read), 32'h0);
        check("rst_address", 32'(flash.address), 32'h0);
        check("rst_underrun", 32'(underrun_cnt), 32'h0);
        rst = 1'b0;

        // forward, zero-wait
        fixed_data = 32'hBBBB_AAAA; ws_cfg = 0; lat_cfg = 1; addr = 0; dir = 1; playpause = 1;
        sb = samp_log.size(); ab = adv_cnt; rb = req_log.size();
        for (int i = 0; i < 60; i++) cyc(i % 20 == 10);
        check("fwd_first", 32'(samp_log[sb]), 32'hAAAA);
        check("fwd_second", 32'(samp_log[sb+1]), 32'hBBBB);
        check("fwd_adv_once", 32'(adv_cnt - ab), 32'd1);
        check("fwd_addr0", 32'(req_log[rb]), 32'd0);
        check("fwd_next_addr", 32'(req_log[rb+1]), 32'd1);

        // reverse
        playpause = 0;
        do_reset();
        fixed_data = 32'h2222_1111; addr = 23'd5; dir = 0; playpause = 1;
        sb = samp_log.size(); ab = adv_cnt; rb = req_log.size();
        for (int i = 0; i < 50; i++) cyc(i % 20 == 10 && i < 40);
        check("rev_first", 32'(samp_log[sb]), 32'h2222);
        check("rev_second", 32'(samp_log[sb+1]), 32'h1111);
        check("rev_adv_once", 32'(adv_cnt - ab), 32'd1);
        check("rev_addr", 32'(req_log[rb]), 32'd5);

        // stalled request and slow data
        playpause = 0;
        do_reset();
        fixed_data = 32'h1234_5678; ws_cfg = 3; lat_cfg = 4; addr = 0; dir = 1; playpause = 1;
        hb = read_hi; sb = samp_log.size(); vb = valid_cnt;
        for (int i = 0; i < 15; i++) cyc(0);
        check("stall_read_cycles", 32'(read_hi - hb), 32'd4);
        cyc(1);
        cyc(0);
        check("stall_sample", 32'(samp_log[sb]), 32'h5678);
        check("stall_one_valid", 32'(valid_cnt - vb), 32'd1);

        // data valid in the acceptance cycle, reverse order
        playpause = 0;
        do_reset();
        fixed_data = 32'h0F0F_F0F0; ws_cfg = 1; lat_cfg = 0; dir = 0; playpause = 1;
        sb = samp_log.size(); vb = valid_cnt;
        for (int i = 0; i < 8; i++) cyc(0);
        cyc(1);
        cyc(0);
        check("lat0_sample", 32'(samp_log[sb]), 32'h0F0F);
        check("lat0_one_valid", 32'(valid_cnt - vb), 32'd1);

        // pending tick and underrun saturation
        playpause = 0;
        do_reset();
        fixed_data = 32'hBEEF_CAFE; ws_cfg = 0; lat_cfg = 2; dir = 1; playpause = 1;
        sb = samp_log.size(); vb = valid_cnt;
        cyc(1);
        for (int i = 0; i < 6; i++) cyc(0);
        check("pend_valid", 32'(valid_cnt - vb), 32'd1);
        check("pend_sample", 32'(samp_log[sb]), 32'hCAFE);
        check("pend_no_underrun", 32'(underrun_cnt), 32'd0);
        ws_cfg = 12;
        cyc(1);
        for (int i = 0; i < 3; i++) cyc(1);
        cyc(0);
        check("underrun_two", 32'(underrun_cnt), 32'd2);
        for (int i = 0; i < 6; i++) cyc(1);
        cyc(0);
        check("underrun_sat", 32'(underrun_cnt), 32'd3);
        ws_cfg = 0;
        for (int i = 0; i < 30; i++) cyc(0);
        check("pend_total_valid", 32'(valid_cnt - vb), 32'd3);

        // pause while data is outstanding
        playpause = 0;
        do_reset();
        fixed_data = 32'h7777_6666; ws_cfg = 0; lat_cfg = 5; dir = 1; playpause = 1;
        vb = valid_cnt;
        for (int i = 0; i < 3; i++) cyc(0);
        playpause = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            cyc(0);
            cyc(0);
        end
        check("pause_no_valid", 32'(valid_cnt - vb), 32'd0);
        check("pause_no_underrun", 32'(underrun_cnt), 32'd0);
        playpause = 1;
        cyc(0);
        #2 check("resume_quiet", 32'(sample_valid), 32'd0);
        cyc(1);
        #2 check("resume_valid", 32'(sample_valid), 32'd1);
        check("resume_sample", 32'(audio_sample), 32'h6666);

        // reset in the middle of a request, then a stray readdatavalid
        ws_cfg = 10;
        cyc(1);
        for (int i = 0; i < 3; i++) cyc(0);
        check("midreq_read", 32'(flash.read), 32'd1);
        rst = 1'b1;
        #1;
        check("async_read", 32'(flash.read), 32'd0);
        check("async_sample", 32'(audio_sample), 32'd0);
        check("async_valid", 32'(sample_valid), 32'd0);
        check("async_adv", 32'(addr_adv), 32'd0);
        check("async_address", 32'(flash.address), 32'd0);
        cyc(0);
        cyc(0);
        rst = 1'b0; playpause = 0; ws_cfg = 0; lat_cfg = 2; stray = 1;
        vb = valid_cnt;
        cyc(0);
        cyc(0);
        cyc(1);
        playpause = 1;
        #2 check("stray_ignored", 32'(sample_valid), 32'd0);
        for (int i = 0; i < 10; i++) cyc(0);
        check("stray_no_valid", 32'(valid_cnt - vb), 32'd1);

        // randomized traffic
        rand_mode = 1; fixed_en = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 199) == 0) playpause = ~playpause;
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            if ($urandom_range(0, 79) == 0) stray = 1;
            if (i % 1000 == 999) begin
                rst = 1'b1;
                cyc(0);
                rst = 1'b0;
            end
        end
        cyc(0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
